// File: rtl/dcache_pkg.sv
// Shared types for the dcache memory scheduler.
// Channel FSM encoding and consumer-index width helper.
package dcache_pkg;

    typedef enum logic [2:0] {
        IDLE           = 3'b000,
        READ_WAITING   = 3'b010,
        WRITE_WAITING  = 3'b011,
        READ_RELAYING  = 3'b100,
        WRITE_RELAYING = 3'b101
    } ch_state_e;

    function automatic int cidx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int NUM_CONSUMERS_DEF = 8;
    localparam int CIDX_BITS = cidx_bits(NUM_CONSUMERS_DEF);

endpackage

// File: rtl/dcache_mem_channel.sv
// One memory channel: latches a granted request, waits for memory,
// then relays the response until the consumer drops valid.
module dcache_mem_channel
    import dcache_pkg::*;
#(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8,
    parameter int CIDX_W    = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_grant,
    input  logic                 i_grant_write,
    input  logic [CIDX_W-1:0]    i_grant_cidx,
    input  logic [ADDR_BITS-1:0] i_grant_addr,
    input  logic [DATA_BITS-1:0] i_grant_wdata,
    input  logic                 i_cons_read_valid,
    input  logic                 i_cons_write_valid,
    input  logic                 i_mem_read_ready,
    input  logic [DATA_BITS-1:0] i_mem_read_data,
    input  logic                 i_mem_write_ready,
    output ch_state_e            o_state,
    output logic [CIDX_W-1:0]    o_cidx,
    output logic [DATA_BITS-1:0] o_read_data,
    output logic                 o_release,
    output logic                 o_mem_read_valid,
    output logic [ADDR_BITS-1:0] o_mem_read_address,
    output logic                 o_mem_write_valid,
    output logic [ADDR_BITS-1:0] o_mem_write_address,
    output logic [DATA_BITS-1:0] o_mem_write_data
);

    ch_state_e            r_state;
    ch_state_e            w_state_next;
    logic                 w_release;
    logic [CIDX_W-1:0]    r_cidx;
    logic [ADDR_BITS-1:0] r_addr;
    logic [DATA_BITS-1:0] r_wdata;
    logic [DATA_BITS-1:0] r_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_release    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (i_grant)
                    w_state_next = i_grant_write ? WRITE_WAITING : READ_WAITING;
            end
            READ_WAITING: begin
                if (i_mem_read_ready) w_state_next = READ_RELAYING;
            end
            WRITE_WAITING: begin
                if (i_mem_write_ready) w_state_next = WRITE_RELAYING;
            end
            READ_RELAYING: begin
                if (!i_cons_read_valid) begin
                    w_state_next = IDLE;
                    w_release    = 1'b1;
                end
            end
            WRITE_RELAYING: begin
                if (!i_cons_write_valid) begin
                    w_state_next = IDLE;
                    w_release    = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Request fields are captured only at grant; later input changes are ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cidx  <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            if (r_state == IDLE && i_grant) begin
                r_cidx  <= i_grant_cidx;
                r_addr  <= i_grant_addr;
                r_wdata <= i_grant_wdata;
            end
            if (r_state == READ_WAITING && i_mem_read_ready)
                r_rdata <= i_mem_read_data;
        end
    end

    assign o_state             = r_state;
    assign o_cidx              = r_cidx;
    assign o_read_data         = r_rdata;
    assign o_release           = w_release;
    assign o_mem_read_valid    = (r_state == READ_WAITING);
    assign o_mem_read_address  = r_addr;
    assign o_mem_write_valid   = (r_state == WRITE_WAITING);
    assign o_mem_write_address = r_addr;
    assign o_mem_write_data    = r_wdata;

endmodule

// File: rtl/dcache_mem_scheduler.sv
// Shares a pool of memory channels among dcache miss requesters
// using a round-robin allocator over idle channels.
module dcache_mem_scheduler
    import dcache_pkg::*;
#(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 8,
    parameter int NUM_CHANNELS  = 2
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [NUM_CONSUMERS-1:0]                 consumer_read_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]                 consumer_read_ready,
    output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]                 consumer_write_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_write_address,
    input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]                 consumer_write_ready,
    output logic [NUM_CHANNELS-1:0]                  mem_read_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_read_address,
    input  logic [NUM_CHANNELS-1:0]                  mem_read_ready,
    input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_read_data,
    output logic [NUM_CHANNELS-1:0]                  mem_write_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_write_address,
    output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_write_data,
    input  logic [NUM_CHANNELS-1:0]                  mem_write_ready
);

    localparam int CW = cidx_bits(NUM_CONSUMERS);

    logic [CW-1:0]            r_rr_ptr;
    logic [NUM_CONSUMERS-1:0] r_claimed;

    ch_state_e            w_state      [NUM_CHANNELS];
    logic [CW-1:0]        w_cidx       [NUM_CHANNELS];
    logic [DATA_BITS-1:0] w_rdata      [NUM_CHANNELS];
    logic [CW-1:0]        w_grant_cidx [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]  w_grant;
    logic [NUM_CHANNELS-1:0]  w_grant_write;
    logic [NUM_CHANNELS-1:0]  w_release;
    logic [NUM_CONSUMERS-1:0] w_pending;
    logic [NUM_CONSUMERS-1:0] w_grant_mask;
    logic [NUM_CONSUMERS-1:0] w_release_mask;
    logic [CW-1:0]            w_ptr_next;

    assign w_pending = (consumer_read_valid | consumer_write_valid) & ~r_claimed;

    // Channels are filled in index order; a taken consumer is masked out.
    always_comb begin
        logic [NUM_CONSUMERS-1:0] avail;
        logic [CW-1:0]            idx;
        logic                     found;
        avail        = w_pending;
        idx          = '0;
        found        = 1'b0;
        w_ptr_next   = r_rr_ptr;
        w_grant_mask = '0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            w_grant[ch]       = 1'b0;
            w_grant_write[ch] = 1'b0;
            w_grant_cidx[ch]  = '0;
            found             = 1'b0;
            if (w_state[ch] == IDLE) begin
                for (int k = 0; k < NUM_CONSUMERS; k++) begin
                    idx = CW'((int'(r_rr_ptr) + k) % NUM_CONSUMERS);
                    if (!found && avail[idx]) begin
                        found             = 1'b1;
                        w_grant[ch]       = 1'b1;
                        w_grant_cidx[ch]  = idx;
                        w_grant_write[ch] = !consumer_read_valid[idx];
                        avail[idx]        = 1'b0;
                        w_grant_mask[idx] = 1'b1;
                        w_ptr_next = CW'((int'(idx) + 1) % NUM_CONSUMERS);
                    end
                end
            end
        end
    end

    always_comb begin
        w_release_mask = '0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++)
            if (w_release[ch]) w_release_mask[w_cidx[ch]] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr  <= '0;
            r_claimed <= '0;
        end else begin
            r_claimed <= (r_claimed | w_grant_mask) & ~w_release_mask;
            if (|w_grant) r_rr_ptr <= w_ptr_next;
        end
    end

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
        logic [CW-1:0] w_gc;
        assign w_gc = w_grant_cidx[g];
        dcache_mem_channel #(
            .ADDR_BITS (ADDR_BITS),
            .DATA_BITS (DATA_BITS),
            .CIDX_W    (CW)
        ) u_ch (
            .clk                 (clk),
            .reset               (reset),
            .i_grant             (w_grant[g]),
            .i_grant_write       (w_grant_write[g]),
            .i_grant_cidx        (w_gc),
            .i_grant_addr        (w_grant_write[g] ? consumer_write_address[w_gc]
                                                   : consumer_read_address[w_gc]),
            .i_grant_wdata       (consumer_write_data[w_gc]),
            .i_cons_read_valid   (consumer_read_valid[w_cidx[g]]),
            .i_cons_write_valid  (consumer_write_valid[w_cidx[g]]),
            .i_mem_read_ready    (mem_read_ready[g]),
            .i_mem_read_data     (mem_read_data[g]),
            .i_mem_write_ready   (mem_write_ready[g]),
            .o_state             (w_state[g]),
            .o_cidx              (w_cidx[g]),
            .o_read_data         (w_rdata[g]),
            .o_release           (w_release[g]),
            .o_mem_read_valid    (mem_read_valid[g]),
            .o_mem_read_address  (mem_read_address[g]),
            .o_mem_write_valid   (mem_write_valid[g]),
            .o_mem_write_address (mem_write_address[g]),
            .o_mem_write_data    (mem_write_data[g])
        );
    end

    always_comb begin
        consumer_read_ready  = '0;
        consumer_read_data   = '0;
        consumer_write_ready = '0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            if (w_state[ch] == READ_RELAYING) begin
                consumer_read_ready[w_cidx[ch]] = 1'b1;
                consumer_read_data[w_cidx[ch]]  = w_rdata[ch];
            end
            if (w_state[ch] == WRITE_RELAYING)
                consumer_write_ready[w_cidx[ch]] = 1'b1;
        end
    end

endmodule

// File: tb/tb_dcache_mem_scheduler.sv
// Directed bench with a memory responder model and a response scoreboard.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_dcache_mem_scheduler;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [7:0]      crv, cwv, crr, cwr;
    logic [7:0][7:0] cra, cwa, cwd, crd;
    logic [1:0]      mrv, mrr, mwv, mwr;
    logic [1:0][7:0] mra, mrd, mwa, mwd;

    always #5 clk = ~clk;

    dcache_mem_scheduler #(
        .ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(8), .NUM_CHANNELS(2)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .consumer_read_valid    (crv),
        .consumer_read_address  (cra),
        .consumer_read_ready    (crr),
        .consumer_read_data     (crd),
        .consumer_write_valid   (cwv),
        .consumer_write_address (cwa),
        .consumer_write_data    (cwd),
        .consumer_write_ready   (cwr),
        .mem_read_valid         (mrv),
        .mem_read_address       (mra),
        .mem_read_ready         (mrr),
        .mem_read_data          (mrd),
        .mem_write_valid        (mwv),
        .mem_write_address      (mwa),
        .mem_write_data         (mwd),
        .mem_write_ready        (mwr)
    );

    typedef struct {
        bit       wr;
        int       c;
        logic [7:0] d;
    } exp_t;

    exp_t sb[$];
    int   glog[$];
    logic [7:0] mem [256];
    int   checks = 0;
    int   failures = 0;
    int   dly = 1;
    int   rcnt [2];
    int   wcnt [2];
    int   reissue_left [8];
    logic [7:0] prev_rr, prev_wr, nodrop, raise_next;
    logic [1:0] prev_mrv, prev_mwv;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input bit wr, input int c, input logic [7:0] d);
        exp_t e;
        e.wr = wr;
        e.c  = c;
        e.d  = d;
        sb.push_back(e);
    endtask

    task automatic sb_check(input bit wr, input int c, input logic [7:0] obs);
        int hit = -1;
        for (int i = 0; i < sb.size(); i++)
            if (hit < 0 && sb[i].wr == wr && sb[i].c == c) hit = i;
        chk("sb_found", 32'(hit >= 0), 32'd1);
        if (hit >= 0) begin
            chk(wr ? "sb_wdata" : "sb_rdata", 32'(obs), 32'(sb[hit].d));
            sb.delete(hit);
        end
    endtask

    task automatic rd(input int c, input logic [7:0] a);
        cra[c] = a;
        crv[c] = 1'b1;
        push(1'b0, c, mem[a]);
    endtask

    task automatic wr(input int c, input logic [7:0] a, input logic [7:0] d);
        cwa[c] = a;
        cwd[c] = d;
        cwv[c] = 1'b1;
        push(1'b1, c, d);
    endtask

    task automatic step();
        @(negedge clk);
        for (int c = 0; c < 8; c++)
            if (raise_next[c]) begin
                raise_next[c] = 1'b0;
                rd(c, cra[c]);
            end
        for (int ch = 0; ch < 2; ch++) begin
            if (mrv[ch] && !prev_mrv[ch]) glog.push_back(int'(mra[ch]));
            if (mwv[ch] && !prev_mwv[ch]) glog.push_back(256 + int'(mwa[ch]));
        end
        prev_mrv = mrv;
        prev_mwv = mwv;
        for (int c = 0; c < 8; c++) begin
            if (crr[c] && !prev_rr[c]) begin
                sb_check(1'b0, c, crd[c]);
                if (!nodrop[c]) begin
                    crv[c] = 1'b0;
                    if (reissue_left[c] > 0) begin
                        reissue_left[c]--;
                        raise_next[c] = 1'b1;
                    end
                end
            end
            if (cwr[c] && !prev_wr[c]) begin
                sb_check(1'b1, c, mem[cwa[c]]);
                if (!nodrop[c]) cwv[c] = 1'b0;
            end
        end
        prev_rr = crr;
        prev_wr = cwr;
        for (int ch = 0; ch < 2; ch++) begin
            if (mrv[ch] && !mrr[ch]) begin
                rcnt[ch]++;
                if (rcnt[ch] >= dly) begin
                    mrr[ch] = 1'b1;
                    mrd[ch] = mem[mra[ch]];
                    rcnt[ch] = 0;
                end
            end else begin
                mrr[ch] = 1'b0;
                rcnt[ch] = 0;
            end
            if (mwv[ch] && !mwr[ch]) begin
                wcnt[ch]++;
                if (wcnt[ch] >= dly) begin
                    mwr[ch] = 1'b1;
                    mem[mwa[ch]] = mwd[ch];
                    wcnt[ch] = 0;
                end
            end else begin
                mwr[ch] = 1'b0;
                wcnt[ch] = 0;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        crv = '0;
        cwv = '0;
        mrr = '0;
        mwr = '0;
        nodrop = '0;
        raise_next = '0;
        sb.delete();
        glog.delete();
        for (int i = 0; i < 8; i++) reissue_left[i] = 0;
        for (int i = 0; i < 2; i++) begin
            rcnt[i] = 0;
            wcnt[i] = 0;
        end
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((sb.size() != 0 || crv != 0 || cwv != 0 || raise_next != 0)
               && n < 200) begin
            step();
            n++;
        end
        chk({tag, "_drain"}, 32'(sb.size()), 32'd0);
        step();
    endtask

    initial begin
        int p7, p0b, n0;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[8'h42] = 8'hA5;
        cra = '0; cwa = '0; cwd = '0; mrd = '0;
        prev_rr = '0; prev_wr = '0; prev_mrv = '0; prev_mwv = '0;
        do_reset();
        reset = 1'b1;
        #1;
        chk("rst_crr", 32'(crr), 0);
        chk("rst_cwr", 32'(cwr), 0);
        chk("rst_crd", 32'(crd), 0);
        chk("rst_mrv", 32'(mrv), 0);
        chk("rst_mwv", 32'(mwv), 0);
        chk("rst_mwd", 32'(mwd), 0);
        chk("rst_ptr", 32'(dut.r_rr_ptr), 0);
        chk("rst_claim", 32'(dut.r_claimed), 0);
        reset = 1'b0;

        // single read, memory answers two cycles after valid
        dly = 2;
        rd(3, 8'h42);
        step();
        chk("rd_mrv", 32'(mrv), 32'h1);
        chk("rd_mra", 32'(mra[0]), 32'h42);
        chk("rd_crr_early", 32'(crr), 0);
        step();
        step();
        chk("rd_crr", 32'(crr), 32'h08);
        chk("rd_crd", 32'(crd[3]), 32'hA5);
        chk("rd_mrv_drop", 32'(mrv), 0);
        step();
        chk("rd_release", 32'(crr), 0);
        chk("rd_claim", 32'(dut.r_claimed), 0);
        drain("rd");

        // single write, ready held until valid drops
        dly = 1;
        nodrop[0] = 1'b1;
        wr(0, 8'h10, 8'h7E);
        step();
        chk("wr_mwv", 32'(mwv), 32'h1);
        chk("wr_mwa", 32'(mwa[0]), 32'h10);
        chk("wr_mwd", 32'(mwd[0]), 32'h7E);
        step();
        chk("wr_cwr", 32'(cwr), 32'h1);
        step();
        step();
        chk("wr_hold", 32'(cwr), 32'h1);
        nodrop[0] = 1'b0;
        cwv[0] = 1'b0;
        step();
        chk("wr_release", 32'(cwr), 0);
        drain("wr");

        // contention across both channels
        do_reset();
        rd(0, 8'h40);
        rd(1, 8'h41);
        rd(2, 8'h42);
        rd(5, 8'h45);
        step();
        chk("ct_mrv", 32'(mrv), 32'h3);
        chk("ct_ch0", 32'(mra[0]), 32'h40);
        chk("ct_ch1", 32'(mra[1]), 32'h41);
        chk("ct_ptr", 32'(dut.r_rr_ptr), 32'd2);
        step();
        step();
        step();
        chk("ct_mrv2", 32'(mrv), 32'h3);
        chk("ct_ch0b", 32'(mra[0]), 32'h42);
        chk("ct_ch1b", 32'(mra[1]), 32'h45);
        chk("ct_ptr2", 32'(dut.r_rr_ptr), 32'd6);
        drain("ct");

        // fairness: 7 must win over 0's re-request
        do_reset();
        nodrop[1] = 1'b1;
        reissue_left[0] = 1;
        rd(0, 8'h40);
        rd(1, 8'h41);
        step();
        rd(7, 8'h47);
        repeat (10) step();
        p7 = -1;
        p0b = -1;
        n0 = 0;
        for (int i = 0; i < glog.size(); i++) begin
            if (glog[i] == 'h47 && p7 < 0) p7 = i;
            if (glog[i] == 'h40) begin
                n0++;
                if (n0 == 2) p0b = i;
            end
        end
        chk("fair_n0", 32'(n0), 32'd2);
        chk("fair_order", 32'(p7 >= 0 && p7 < p0b), 32'd1);
        nodrop[1] = 1'b0;
        crv[1] = 1'b0;
        drain("fair");

        // read and write from one consumer: read first
        glog.delete();
        rd(4, 8'h44);
        wr(4, 8'h84, 8'h3C);
        step();
        chk("rw_mrv", 32'(mrv), 32'h1);
        chk("rw_mwv", 32'(mwv), 0);
        chk("rw_mra", 32'(mra[0]), 32'h44);
        drain("rw");
        chk("rw_first", 32'(glog[0]), 32'h44);
        chk("rw_second", 32'(glog[1]), 32'h184);
        chk("rw_mem", 32'(mem[8'h84]), 32'h3C);

        // reset in the middle of a read
        dly = 6;
        rd(6, 8'h46);
        step();
        step();
        chk("rm_mrv", 32'(mrv), 32'h1);
        reset = 1'b1;
        #1;
        chk("rm_mrv0", 32'(mrv), 0);
        chk("rm_crr0", 32'(crr), 0);
        chk("rm_state", 32'(dut.w_state[0]), 0);
        chk("rm_claim", 32'(dut.r_claimed), 0);
        do_reset();
        dly = 1;
        rd(6, 8'h46);
        step();
        chk("rm_again", 32'(mra[0]), 32'h46);
        drain("rm");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
